// File: rtl/i2c_reg_access.sv
// i2c_reg_access: sequences register reads/writes onto a byte-level I2C master.
// Define I2C_REG_RETRY_EN to retry address NACKs up to RETRY_LIMIT extra times.
module i2c_reg_access #(
  parameter int DEV_ADDR_BITS  = 7,
  parameter int TIMEOUT_CYCLES = 4095,
  parameter int RETRY_LIMIT    = 2
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     reqValid,
  output logic                     reqReady,
  input  logic                     reqRead,
  input  logic [DEV_ADDR_BITS-1:0] reqDev,
  input  logic [7:0]               reqReg,
  input  logic [7:0]               reqWrData,
  output logic                     rspValid,
  output logic [7:0]               rspData,
  output logic [1:0]               rspStatus,
  output logic                     mStart,
  output logic                     mStop,
  output logic                     mReadNWrite,
  output logic [9:0]               mDIn,
  output logic                     mSendAck,
  input  logic                     mBusy,
  input  logic                     mRecvAck,
  input  logic                     mDOutStrobe,
  input  logic [7:0]               mDOut
);
  typedef enum logic [2:0] {IDLE, ADDR, REG, WDATA, RESTART, RDATA, STOP, DONE} state_t;
  typedef enum logic [1:0] {ISSUE, WAIT_HI, WAIT_LO} phase_t;
  state_t st, nst;
  phase_t ph;
  logic [11:0] wd, wd_inc;
  logic [1:0] nstat;
  logic rd, act, fin, tmo, retry, rpend;
  logic [DEV_ADDR_BITS-1:0] dev;
  logic [7:0] rg, wdat;
`ifdef I2C_REG_RETRY_EN
  logic [7:0] rc;
`endif
  assign mSendAck = 1'b0;
  always_comb begin
    act = st != IDLE && st != DONE;
    fin = act && ph == WAIT_LO && !mBusy;
    wd_inc = wd + 12'd1;
    tmo = act && ph != ISSUE && !fin && wd_inc == 12'(TIMEOUT_CYCLES);
    retry = 1'b0;
    nst = st;
    nstat = rspStatus;
    case (st)
      IDLE: nst = reqValid ? ADDR : IDLE;
      ADDR: if (fin) begin
`ifdef I2C_REG_RETRY_EN
        retry = !mRecvAck && rc < 8'(RETRY_LIMIT);
`endif
        nst = mRecvAck ? REG : STOP;
        nstat = mRecvAck || retry ? rspStatus : 2'b01;
      end
      REG: if (fin) begin
        nst = !mRecvAck ? STOP : rd ? RESTART : WDATA;
        nstat = mRecvAck ? rspStatus : 2'b10;
      end
      WDATA: if (fin) begin
        nst = STOP;
        nstat = mRecvAck ? rspStatus : 2'b10;
      end
      RESTART: if (fin) begin
        nst = mRecvAck ? RDATA : STOP;
        nstat = mRecvAck ? rspStatus : 2'b01;
      end
      RDATA: if (fin) nst = STOP;
      STOP: if (fin) nst = rpend ? ADDR : DONE;
      default: nst = IDLE;
    endcase
    if (tmo) begin
      nst = DONE;
      nstat = 2'b11;
    end
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      st <= IDLE;
      ph <= ISSUE;
      wd <= '0;
      rd <= 1'b0;
      dev <= '0;
      rg <= '0;
      wdat <= '0;
      reqReady <= 1'b1;
      rspValid <= 1'b0;
      rspData <= '0;
      rspStatus <= '0;
      mStart <= 1'b0;
      mStop <= 1'b0;
      mReadNWrite <= 1'b0;
      mDIn <= '0;
    end else begin
      st <= nst;
      rspStatus <= nstat;
      rspValid <= nst == DONE;
      reqReady <= nst == IDLE;
      mStart <= 1'b0;
      mStop <= 1'b0;
      wd <= act && ph != ISSUE ? wd_inc : 12'd0;
      if (nst != st) ph <= ISSUE;
      else if (act) ph <= ph == ISSUE ? WAIT_HI : ph == WAIT_HI && mBusy ? WAIT_LO : ph;
      if (st == IDLE && reqValid) begin
        rd <= reqRead;
        dev <= reqDev;
        rg <= reqReg;
        wdat <= reqWrData;
        rspData <= 8'd0;
        rspStatus <= 2'b00;
      end
      if (st == RDATA && mDOutStrobe) rspData <= mDOut;
      // Command outputs are loaded on entry so they are valid throughout ISSUE.
      if (nst != st && nst != IDLE && nst != DONE) begin
        mStart <= nst == ADDR || nst == RESTART;
        mStop <= nst == STOP;
        mReadNWrite <= nst == RESTART || nst == RDATA;
        mDIn <= nst == ADDR || nst == RESTART ? 10'(st == IDLE ? reqDev : dev) :
                nst == REG ? {2'b00, rg} : nst == WDATA ? {2'b00, wdat} : 10'd0;
      end
    end
`ifdef I2C_REG_RETRY_EN
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      rc <= '0;
      rpend <= 1'b0;
    end else if (st == IDLE) begin
      rc <= '0;
      rpend <= 1'b0;
    end else if (retry) begin
      rc <= rc + 8'd1;
      rpend <= 1'b1;
    end else if (st == STOP && fin) rpend <= 1'b0;
`else
  assign rpend = 1'b0;
`endif
endmodule

// File: tb/tb_i2c_reg_access.sv
// tb_i2c_reg_access: bench for i2c_reg_access with a reactive byte-level master model.
module tb_i2c_reg_access;
  localparam int K_ST = 4096, K_WB = 8192, K_RB = 12288 + 1024, K_SP = 16384;
  logic clk = 0, resetN = 1;
  logic reqValid = 0, reqReady, reqRead = 0;
  logic [6:0] reqDev = 0;
  logic [7:0] reqReg = 0, reqWrData = 0;
  logic rspValid;
  logic [7:0] rspData;
  logic [1:0] rspStatus;
  logic mStart, mStop, mReadNWrite, mSendAck;
  logic [9:0] mDIn;
  logic mBusy = 0, mRecvAck = 0, mDOutStrobe = 0;
  logic [7:0] mDOut = 0;

  typedef struct {
    logic       rd;
    logic [6:0] dev;
    logic [7:0] rg;
    logic [7:0] wd;
    logic [7:0] rdat;
    int         nack;
    logic       nstarts;
    logic [1:0] st;
    logic [7:0] data;
  } vec_t;
  vec_t vecs[9];
  int exp_ops[$];
  int exp_rsp[$];
  int n_chk = 0, n_fail = 0, cyc = 0, op_n = 0, nack_at = -1, busy_len = 2, cnt = 0;
  int cur_kind = 0, stops = 0, ops_seen = 0, code;
  logic never_busy = 0, nack_starts = 0, saw_rbyte = 0;
  logic [7:0] rd_byte = 0;

  i2c_reg_access #(.TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .resetN(resetN), .reqValid(reqValid), .reqReady(reqReady), .reqRead(reqRead),
    .reqDev(reqDev), .reqReg(reqReg), .reqWrData(reqWrData), .rspValid(rspValid),
    .rspData(rspData), .rspStatus(rspStatus), .mStart(mStart), .mStop(mStop),
    .mReadNWrite(mReadNWrite), .mDIn(mDIn), .mSendAck(mSendAck), .mBusy(mBusy),
    .mRecvAck(mRecvAck), .mDOutStrobe(mDOutStrobe), .mDOut(mDOut)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Master model: every active cycle without busy or a pending op is an ISSUE cycle.
  initial forever begin
    @(negedge clk);
    mDOutStrobe = 0;
    if (!resetN) begin
      mBusy = 0;
      cnt = 0;
      op_n = 0;
    end else begin
      if (mStop) stops++;
      if (rspValid) op_n = 0;
      if (cnt > 0) begin
        cnt--;
        if (cur_kind == 3 && cnt == busy_len - 1) begin
          mDOutStrobe = 1;
          mDOut = rd_byte;
        end
        if (cnt == 0) begin
          mBusy = 0;
          mRecvAck = !(op_n == nack_at || (nack_starts && cur_kind == 1));
          op_n++;
        end
      end else if (!never_busy && !reqReady && !rspValid) begin
        cur_kind = mStart ? 1 : mStop ? 4 : mReadNWrite ? 3 : 2;
        code = cur_kind == 4 ? K_SP : cur_kind == 3 ? K_RB + int'(mSendAck) * 2048 :
               cur_kind * 4096 + int'(mReadNWrite) * 1024 + int'(mDIn);
        ops_seen++;
        if (cur_kind == 3) saw_rbyte = 1;
        if (exp_ops.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL op: unexpected master op %0h", code);
        end else chk("op", code, exp_ops.pop_front());
        mBusy = 1;
        cnt = busy_len;
      end
    end
  end

  task automatic build(input vec_t v);
    int n = 1;
`ifdef I2C_REG_RETRY_EN
    n = 3;
`endif
    if (v.nstarts) begin
      repeat (n) begin
        exp_ops.push_back(K_ST + int'(v.dev));
        exp_ops.push_back(K_SP);
      end
      return;
    end
    exp_ops.push_back(K_ST + int'(v.dev));
    exp_ops.push_back(K_WB + int'(v.rg));
    if (v.nack == 1) begin
      exp_ops.push_back(K_SP);
      return;
    end
    if (!v.rd) begin
      exp_ops.push_back(K_WB + int'(v.wd));
      exp_ops.push_back(K_SP);
      return;
    end
    exp_ops.push_back(K_ST + 1024 + int'(v.dev));
    if (v.nack != 2) exp_ops.push_back(K_RB);
    exp_ops.push_back(K_SP);
  endtask

  task automatic drive(input vec_t v);
    reqRead = v.rd;
    reqDev = v.dev;
    reqReg = v.rg;
    reqWrData = v.wd;
    reqValid = 1;
  endtask

  task automatic wait_rsp();
    int e;
    for (int i = 0; i < 300 && !rspValid; i++) @(negedge clk);
    if (!rspValid) begin
      n_chk++;
      n_fail++;
      $display("FAIL rsp_wait: no rspValid within 300 cycles");
    end else if (exp_rsp.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL rsp: unexpected response status %0h", rspStatus);
    end else begin
      e = exp_rsp.pop_front();
      chk("rsp_status", int'(rspStatus), (e >> 8) & 3);
      chk("rsp_data", int'(rspData), e & 255);
    end
  endtask

  task automatic run(input vec_t v);
    nack_at = v.nack;
    nack_starts = v.nstarts;
    rd_byte = v.rdat;
    build(v);
    exp_rsp.push_back(int'({v.st, v.data}));
    drive(v);
    @(negedge clk);
    reqValid = 0;
    wait_rsp();
    @(negedge clk);
    chk("rsp_one_cycle", int'(rspValid), 0);
    chk("ready_after", int'(reqReady), 1);
    chk("ops_left", exp_ops.size(), 0);
  endtask

  task automatic chk_rst(input string t);
    chk({t, "_ready"}, int'(reqReady), 1);
    chk({t, "_rspvalid"}, int'(rspValid), 0);
    chk({t, "_rspdata"}, int'(rspData), 0);
    chk({t, "_status"}, int'(rspStatus), 0);
    chk({t, "_cmd"}, int'({mStart, mStop, mReadNWrite, mSendAck, mDIn}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t a, b;
    int t0, s, n;
    vecs[0] = '{1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, -1, 1'b0, 2'b00, 8'h00};
    vecs[1] = '{1'b1, 7'h50, 8'h22, 8'h00, 8'h3C, -1, 1'b0, 2'b00, 8'h3C};
    vecs[2] = '{1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 1, 1'b0, 2'b10, 8'h00};
    vecs[3] = '{1'b0, 7'h50, 8'h33, 8'h5A, 8'h00, 2, 1'b0, 2'b10, 8'h00};
    vecs[4] = '{1'b1, 7'h50, 8'h22, 8'h00, 8'h3C, 2, 1'b0, 2'b01, 8'h00};
    vecs[5] = '{1'b0, 7'h7F, 8'hFF, 8'h00, 8'h00, -1, 1'b0, 2'b00, 8'h00};
    vecs[6] = '{1'b1, 7'h00, 8'h00, 8'h00, 8'hFF, -1, 1'b0, 2'b00, 8'hFF};
    vecs[7] = '{1'b1, 7'h2A, 8'h81, 8'h00, 8'h3C, 1, 1'b0, 2'b10, 8'h00};
    vecs[8] = '{1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, -1, 1'b1, 2'b01, 8'h00};
    #1 resetN = 0;
    #1 chk_rst("reset");
    repeat (3) @(negedge clk);
    resetN = 1;
    @(negedge clk);
    for (int i = 0; i < 9; i++) run(vecs[i]);
    nack_at = -1;
    nack_starts = 0;
    // Watchdog: master never goes busy.
    never_busy = 1;
    s = stops;
    exp_rsp.push_back(int'({2'b11, 8'h00}));
    drive(vecs[1]);
    @(negedge clk);
    reqValid = 0;
    for (int i = 0; i < 10 && !mStart; i++) @(negedge clk);
    chk("timeout_start", int'(mStart), 1);
    t0 = cyc;
    wait_rsp();
    chk("timeout_latency", cyc - t0, 21);
    chk("timeout_no_stop", stops - s, 0);
    @(negedge clk);
    never_busy = 0;
    // Request held across a transaction is taken only after DONE.
    a = vecs[0];
    b = '{1'b1, 7'h3A, 8'h05, 8'h00, 8'h77, -1, 1'b0, 2'b00, 8'h77};
    rd_byte = 8'h77;
    build(a);
    exp_rsp.push_back(int'({a.st, a.data}));
    drive(a);
    @(negedge clk);
    build(b);
    exp_rsp.push_back(int'({b.st, b.data}));
    drive(b);
    wait_rsp();
    @(negedge clk);
    chk("b2b_idle_ready", int'(reqReady), 1);
    chk("b2b_no_early_start", int'(mStart), 0);
    @(negedge clk);
    chk("b2b_start", int'(mStart), 1);
    reqValid = 0;
    wait_rsp();
    @(negedge clk);
    chk("b2b_ops_left", exp_ops.size(), 0);
    // Reset in the middle of the read byte.
    busy_len = 8;
    saw_rbyte = 0;
    rd_byte = 8'hC3;
    build(vecs[1]);
    drive(vecs[1]);
    @(negedge clk);
    reqValid = 0;
    for (int i = 0; i < 60 && !saw_rbyte; i++) @(negedge clk);
    chk("rdata_reached", int'(saw_rbyte), 1);
    repeat (2) @(negedge clk);
    chk("rdata_captured", int'(rspData), 8'hC3);
    #1 resetN = 0;
    #1 chk_rst("mid_reset");
    exp_ops.delete();
    exp_rsp.delete();
    n = ops_seen;
    s = stops;
    @(negedge clk);
    resetN = 1;
    busy_len = 2;
    repeat (6) @(negedge clk);
    chk("no_ops_after_reset", ops_seen - n, 0);
    chk("no_stop_after_reset", stops - s, 0);
    chk("ready_after_reset", int'(reqReady), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
